// File: rtl/conv_chan_sched.sv
// rtl/conv_chan_sched.sv - steps the 3x3 conv engine through output channels, one plane handoff at a time
module conv_chan_sched #(
    parameter int CHAN    = 10,
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       conv_trigger,
    output logic [3:0] conv_chan,
    input  logic       conv_valid,
    input  logic [3:0] conv_out_chan,
    output logic       dn_valid,
    output logic [3:0] dn_chan,
    input  logic       dn_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_HAND, S_DONE} state_t;

    localparam logic [3:0]      LAST_CHAN = 4'(CHAN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [3:0]      cur_chan, cur_chan_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic            err_q, err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_chan <= '0;
            to_cnt   <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_chan <= cur_chan_nx;
            to_cnt   <= to_cnt_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cur_chan_nx = cur_chan;
        to_cnt_nx   = to_cnt;
        err_nx      = err_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    cur_chan_nx = '0;
                    err_nx      = 1'b0;
                    state_nx    = S_TRIG;
                end
            end
            S_TRIG: begin
                to_cnt_nx = '0;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_nx = to_cnt + TO_W'(1);
                // A plane arriving on the last allowed cycle still counts.
                if (conv_valid) begin
                    if (conv_out_chan == cur_chan) begin
                        state_nx = S_HAND;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_HAND: begin
                if (dn_ready) begin
                    if (cur_chan == LAST_CHAN) begin
                        state_nx = S_DONE;
                    end else begin
                        cur_chan_nx = cur_chan + 4'd1;
                        state_nx    = S_TRIG;
                    end
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Abort freezes channel and error state; it also masks a start in IDLE.
        if (abort) begin
            state_nx    = S_IDLE;
            cur_chan_nx = cur_chan;
            to_cnt_nx   = to_cnt;
            err_nx      = err_q;
        end
    end

    assign conv_trigger = (state == S_TRIG);
    assign conv_chan    = cur_chan;
    assign dn_valid     = (state == S_HAND);
    assign dn_chan      = cur_chan;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign err          = err_q;
endmodule

// File: tb/tb_conv_chan_sched.sv
// tb/tb_conv_chan_sched.sv - randomized scoreboard bench for conv_chan_sched
module tb_conv_chan_sched;
    localparam int CHAN    = 10;
    localparam int TIMEOUT = 200;
    localparam int TO_W    = 16;
    localparam int EV_TRIG = 0;
    localparam int EV_HS   = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int chan;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       conv_valid = 1'b0;
    logic [3:0] conv_out_chan = 4'd0;
    logic       dn_ready = 1'b0;
    logic       conv_trigger, dn_valid, busy, done, err;
    logic [3:0] conv_chan, dn_chan;

    conv_chan_sched #(.CHAN(CHAN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .conv_trigger(conv_trigger),
        .conv_chan(conv_chan),
        .conv_valid(conv_valid),
        .conv_out_chan(conv_out_chan),
        .dn_valid(dn_valid),
        .dn_chan(dn_chan),
        .dn_ready(dn_ready),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  eng_delay[CHAN];
    int  eng_tag[CHAN];
    int  rdy_random = 0;
    int  hold_chan = -1;
    int  hold_len = 50;
    int  pass_id = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  n_timeouts = 0;
    bit  end_req = 1'b0;
    bit  end_ack = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic sb(input int kind, input int chan);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_kind", kind, e.kind);
        chk("sb_chan", chan, e.chan);
    endtask

    // Engine: answers each trigger after eng_delay[ch] cycles (0 = never) with tag eng_tag[ch].
    initial begin : engine
        int cnt;
        int tag;
        cnt = 0;
        tag = 0;
        forever begin
            @(posedge clk);
            #1;
            conv_valid = 1'b0;
            if (!busy) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    conv_valid    = 1'b1;
                    conv_out_chan = 4'(tag);
                end
            end
            if (conv_trigger) begin
                cnt = eng_delay[int'(conv_chan)];
                tag = eng_tag[int'(conv_chan)];
            end
        end
    end

    // Consumer: ready always or random, with one hold of hold_len cycles on hold_chan per pass.
    initial begin : consumer
        int hold_cnt;
        int held_id;
        hold_cnt = 0;
        held_id  = -1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                hold_cnt--;
                dn_ready = 1'b0;
            end else if (dn_valid && int'(dn_chan) == hold_chan && held_id != pass_id) begin
                held_id  = pass_id;
                hold_cnt = hold_len - 1;
                dn_ready = 1'b0;
            end else begin
                dn_ready = (rdy_random != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin : monitor
        int         cyc;
        int         last_trig;
        bit         cv_since;
        bit         hs;
        bit         p_rst, p_start, p_abort, p_busy, p_cv, p_dnv, p_dnr, p_hs, p_done, p_err;
        logic [3:0] p_tag, p_cchan, p_dchan;
        cyc = 0; last_trig = -1000; cv_since = 1'b1; hs = 1'b0;
        p_rst = 1'b1; p_start = 1'b0; p_abort = 1'b0; p_busy = 1'b0; p_cv = 1'b0;
        p_dnv = 1'b0; p_dnr = 1'b0; p_hs = 1'b0; p_done = 1'b0; p_err = 1'b0;
        p_tag = 4'd0; p_cchan = 4'd0; p_dchan = 4'd0;
        forever begin
            @(negedge clk);
            cyc++;
            hs = 1'b0;
            if (end_req && !end_ack) begin
                chk("queue_drained", exp_q.size(), 0);
                chk("no_stalled_wait", n_timeouts, 0);
                end_ack = 1'b1;
            end
            if (rst) begin
                chk("rst_outputs_zero",
                    int'({conv_trigger, conv_chan, dn_valid, dn_chan, busy, done, err}), 0);
                cv_since = 1'b1;
            end else begin
                hs = dn_valid && dn_ready && !abort;
                if (err && !p_err) begin
                    chk("err_cause", int'((p_cv && p_tag != p_cchan && !p_abort) ||
                        (!cv_since && cyc == last_trig + 1 + TIMEOUT)), 1);
                    sb(EV_ERR, int'(conv_chan));
                end
                if (conv_trigger) begin
                    chk("trig_cause", int'((p_start && !p_busy && !p_abort && !p_rst) ||
                        (p_hs && p_dchan != 4'(CHAN - 1))), 1);
                    if (p_start && !p_busy) chk("err_cleared_by_start", int'(err), 0);
                    sb(EV_TRIG, int'(conv_chan));
                    last_trig = cyc;
                    cv_since  = 1'b0;
                end else if (conv_valid) begin
                    cv_since = 1'b1;
                end
                if (dn_valid && !p_dnv)
                    chk("dn_valid_latency", int'(p_cv && p_tag == p_cchan && !p_abort), 1);
                if (p_dnv && !p_dnr && !p_abort && !p_rst) begin
                    chk("hold_dn_valid", int'(dn_valid), 1);
                    chk("hold_dn_chan", int'(dn_chan), int'(p_dchan));
                end
                if (hs) sb(EV_HS, int'(dn_chan));
                if (done) begin
                    chk("done_cause", int'(p_hs && p_dchan == 4'(CHAN - 1)), 1);
                    sb(EV_DONE, int'(conv_chan));
                end
                if (p_done) chk("idle_after_done", int'(busy), 0);
                if (p_abort && !p_rst) chk("abort_to_idle", int'({busy, dn_valid, done}), 0);
            end
            p_rst = rst; p_start = start; p_abort = abort; p_busy = busy; p_cv = conv_valid;
            p_dnv = dn_valid; p_dnr = dn_ready; p_hs = hs; p_done = done; p_err = err;
            p_tag = conv_out_chan; p_cchan = conv_chan; p_dchan = dn_chan;
        end
    end

    // Reference model: the event sequence a pass must produce given the engine setup.
    task automatic push_ev(input int kind, input int chan);
        ev_t e;
        e.kind = kind;
        e.chan = chan;
        exp_q.push_back(e);
    endtask

    task automatic model_pass(input int cut);
        for (int ch = 0; ch < CHAN; ch++) begin
            push_ev(EV_TRIG, ch);
            if (ch == cut) return;
            if (eng_delay[ch] == 0 || eng_delay[ch] > TIMEOUT || eng_tag[ch] != ch) begin
                push_ev(EV_ERR, ch);
                return;
            end
            push_ev(EV_HS, ch);
        end
        push_ev(EV_DONE, CHAN - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int dmin, input int dmax, input int rnd, input int hch);
        pass_id++;
        rdy_random = rnd;
        hold_chan  = hch;
        for (int ch = 0; ch < CHAN; ch++) begin
            eng_delay[ch] = $urandom_range(dmax, dmin);
            eng_tag[ch]   = ch;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) n_timeouts++;
        repeat (3) tick();
    endtask

    task automatic wait_trig(input int c);
        int n;
        n = 0;
        while (!(conv_trigger && int'(conv_chan) == c) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) n_timeouts++;
    endtask

    task automatic wait_dnv(input int c);
        int n;
        n = 0;
        while (!(dn_valid && int'(dn_chan) == c) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) n_timeouts++;
    endtask

    initial begin : stimulus
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Full pass with the real plane latency; a start while busy must be ignored.
        setup(182, 182, 0, -1);
        model_pass(-1);
        pulse_start();
        repeat (50) tick();
        pulse_start();
        wait_idle(4000);

        // Backpressure on channel 3, plus plane arriving exactly at the timeout limit.
        setup(1, 20, 0, 3);
        eng_delay[5] = TIMEOUT;
        eng_delay[7] = 1;
        model_pass(-1);
        pulse_start();
        wait_idle(5000);

        // Engine never answers channel 2.
        setup(1, 15, 0, -1);
        eng_delay[2] = 0;
        model_pass(-1);
        pulse_start();
        wait_idle(3000);

        // Plane one cycle too late on channel 0.
        setup(1, 15, 1, -1);
        eng_delay[0] = TIMEOUT + 1;
        model_pass(-1);
        pulse_start();
        wait_idle(3000);

        // Tag mismatch on channel 4.
        setup(1, 15, 1, -1);
        eng_tag[4] = 5;
        model_pass(-1);
        pulse_start();
        wait_idle(3000);

        // Abort while channel 6 is being offered downstream.
        setup(1, 15, 0, 6);
        model_pass(6);
        pulse_start();
        wait_dnv(6);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle(100);

        // Start colliding with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of channel 1's wait.
        setup(20, 40, 0, -1);
        model_pass(1);
        pulse_start();
        wait_trig(1);
        repeat (10) tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Normal randomized pass after reset.
        setup(1, 30, 1, -1);
        model_pass(-1);
        pulse_start();
        wait_idle(5000);

        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
